// File: rtl/video_matrix_3x3_gen.sv
// 3x3 neighbourhood generator: two line buffers feed a shifting window that trails the
// raster Y stream by two pixel clocks, with the frame timing delayed to stay aligned.
module video_matrix_3x3_gen #(
    parameter logic [9:0] IMG_HDISP = 10'd640,
    parameter logic [9:0] IMG_VDISP = 10'd480
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       per_frame_vsync,
    input  logic       per_frame_href,
    input  logic       per_frame_clken,
    input  logic [7:0] per_img_Y,
    output logic       matrix_frame_vsync,
    output logic       matrix_frame_href,
    output logic       matrix_frame_clken,
    output logic [7:0] matrix_p11,
    output logic [7:0] matrix_p12,
    output logic [7:0] matrix_p13,
    output logic [7:0] matrix_p21,
    output logic [7:0] matrix_p22,
    output logic [7:0] matrix_p23,
    output logic [7:0] matrix_p31,
    output logic [7:0] matrix_p32,
    output logic [7:0] matrix_p33
);
    localparam int ADDR_W = (IMG_HDISP > 10'd1) ? $clog2(IMG_HDISP) : 1;

    logic [1:0]        vsyncDly_q;
    logic [1:0]        hrefDly_q;
    logic [1:0]        clkenDly_q;
    logic [9:0]        col_q;
    logic [9:0]        col_d;
    logic [9:0]        colCur;
    logic [1:0]        lineCnt_q;
    logic [1:0]        lineCnt_d;
    logic [7:0]        row1_q;
    logic [7:0]        row2_q;
    logic [7:0]        row3_q;
    logic [7:0]        row1_d;
    logic [7:0]        row2_d;
    logic [7:0]        row3_d;
    logic [7:0]        win_q [3][3];
    logic [7:0]        win_d [3][3];
    logic [7:0]        buf1_q [IMG_HDISP];
    logic [7:0]        buf2_q [IMG_HDISP];
    logic              hrefRise;
    logic              hrefFall;
    logic              vsyncRise;
    logic              colInRange;
    logic              bufWrEn;
    logic [ADDR_W-1:0] bufAddr;

    // Stage 0 of each delay pipe doubles as the edge detector's registered copy.
    assign hrefRise   = per_frame_href & ~hrefDly_q[0];
    assign hrefFall   = ~per_frame_href & hrefDly_q[0];
    assign vsyncRise  = per_frame_vsync & ~vsyncDly_q[0];

    // A strobe coinciding with href rise belongs to column 0 of the new line.
    assign colCur     = hrefRise ? 10'd0 : col_q;
    assign colInRange = (colCur < IMG_HDISP);
    assign bufAddr    = colCur[ADDR_W-1:0];
    assign bufWrEn    = per_frame_clken & colInRange & ~rst;

    always_comb begin
        col_d     = colCur;
        lineCnt_d = lineCnt_q;
        if (per_frame_href && per_frame_clken && colInRange) begin
            col_d = colCur + 10'd1;
        end
        if (vsyncRise) begin
            lineCnt_d = 2'd0;
        end else if (hrefFall && (lineCnt_q != 2'd2)) begin
            lineCnt_d = lineCnt_q + 2'd1;
        end
    end

    // Rows above the current line are masked until enough lines of this frame exist.
    always_comb begin
        row1_d = row1_q;
        row2_d = row2_q;
        row3_d = row3_q;
        if (per_frame_clken) begin
            row3_d = per_img_Y;
            row2_d = 8'd0;
            row1_d = 8'd0;
            if (colInRange && (lineCnt_q != 2'd0)) begin
                row2_d = buf1_q[bufAddr];
            end
            if (colInRange && (lineCnt_q == 2'd2)) begin
                row1_d = buf2_q[bufAddr];
            end
        end
    end

    always_comb begin
        win_d = win_q;
        if (hrefRise) begin
            for (int r = 0; r < 3; r++) begin
                for (int c = 0; c < 3; c++) begin
                    win_d[r][c] = 8'd0;
                end
            end
        end else if (clkenDly_q[0]) begin
            for (int r = 0; r < 3; r++) begin
                win_d[r][0] = win_q[r][1];
                win_d[r][1] = win_q[r][2];
            end
            win_d[0][2] = row1_q;
            win_d[1][2] = row2_q;
            win_d[2][2] = row3_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vsyncDly_q <= 2'd0;
            hrefDly_q  <= 2'd0;
            clkenDly_q <= 2'd0;
            col_q      <= 10'd0;
            lineCnt_q  <= 2'd0;
            row1_q     <= 8'd0;
            row2_q     <= 8'd0;
            row3_q     <= 8'd0;
            for (int r = 0; r < 3; r++) begin
                for (int c = 0; c < 3; c++) begin
                    win_q[r][c] <= 8'd0;
                end
            end
        end else begin
            vsyncDly_q <= {vsyncDly_q[0], per_frame_vsync};
            hrefDly_q  <= {hrefDly_q[0], per_frame_href};
            clkenDly_q <= {clkenDly_q[0], per_frame_clken};
            col_q      <= col_d;
            lineCnt_q  <= lineCnt_d;
            row1_q     <= row1_d;
            row2_q     <= row2_d;
            row3_q     <= row3_d;
            win_q      <= win_d;
        end
    end

    // No reset here so the buffers can map onto block RAM; reads above see the old word.
    always_ff @(posedge clk) begin
        if (bufWrEn) begin
            buf2_q[bufAddr] <= buf1_q[bufAddr];
            buf1_q[bufAddr] <= per_img_Y;
        end
    end

    assign matrix_frame_vsync = vsyncDly_q[1];
    assign matrix_frame_href  = hrefDly_q[1];
    assign matrix_frame_clken = clkenDly_q[1];

    assign matrix_p11 = win_q[0][0];
    assign matrix_p12 = win_q[0][1];
    assign matrix_p13 = win_q[0][2];
    assign matrix_p21 = win_q[1][0];
    assign matrix_p22 = win_q[1][1];
    assign matrix_p23 = win_q[1][2];
    assign matrix_p31 = win_q[2][0];
    assign matrix_p32 = win_q[2][1];
    assign matrix_p33 = win_q[2][2];

endmodule

// File: tb/tb_video_matrix_3x3_gen.sv
// Bench for video_matrix_3x3_gen: directed raster scenarios then random frames, every cycle
// compared against a line-history model of the 3x3 neighbourhood and the 2-clk timing delay.
module tb_video_matrix_3x3_gen;
    localparam logic [9:0] HDISP   = 10'd4;
    localparam int         MAX_CYC = 16384;

    typedef struct {
        int         cyc;
        int         line;
        int         col;
        bit         wrote;
        logic [7:0] pix;
        logic [7:0] mid;
        logic [7:0] top;
    } strobe_t;

    logic       clk;
    logic       rst;
    logic       per_frame_vsync;
    logic       per_frame_href;
    logic       per_frame_clken;
    logic [7:0] per_img_Y;
    logic       matrix_frame_vsync;
    logic       matrix_frame_href;
    logic       matrix_frame_clken;
    logic [7:0] matrix_p11;
    logic [7:0] matrix_p12;
    logic [7:0] matrix_p13;
    logic [7:0] matrix_p21;
    logic [7:0] matrix_p22;
    logic [7:0] matrix_p23;
    logic [7:0] matrix_p31;
    logic [7:0] matrix_p32;
    logic [7:0] matrix_p33;

    video_matrix_3x3_gen #(.IMG_HDISP(HDISP), .IMG_VDISP(10'd3)) dut (
        .clk                (clk),
        .rst                (rst),
        .per_frame_vsync    (per_frame_vsync),
        .per_frame_href     (per_frame_href),
        .per_frame_clken    (per_frame_clken),
        .per_img_Y          (per_img_Y),
        .matrix_frame_vsync (matrix_frame_vsync),
        .matrix_frame_href  (matrix_frame_href),
        .matrix_frame_clken (matrix_frame_clken),
        .matrix_p11         (matrix_p11),
        .matrix_p12         (matrix_p12),
        .matrix_p13         (matrix_p13),
        .matrix_p21         (matrix_p21),
        .matrix_p22         (matrix_p22),
        .matrix_p23         (matrix_p23),
        .matrix_p31         (matrix_p31),
        .matrix_p32         (matrix_p32),
        .matrix_p33         (matrix_p33)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int         testsRun    = 0;
    int         testsFailed = 0;
    int         cyc         = 0;
    int         lineId      = 0;
    int         linesDone   = 0;
    int         colCnt      = 0;
    logic       prevHref    = 1'b0;
    logic       prevVs      = 1'b0;
    logic       vsLvl       = 1'b0;
    logic       rstHist [MAX_CYC];
    logic [2:0] inHist  [MAX_CYC];
    int         lineHist[MAX_CYC];
    strobe_t    strobes [$];

    function automatic logic [71:0] dutWindow();
        return {matrix_p11, matrix_p12, matrix_p13, matrix_p21, matrix_p22, matrix_p23,
                matrix_p31, matrix_p32, matrix_p33};
    endfunction

    task automatic checkOutput(input string tag, input logic [71:0] observed, input logic [71:0] expected);
        testsRun++;
        assert (observed === expected) else begin
            testsFailed++;
            $error("[TB] FAIL %s observed=%h expected=%h cycle=%0d", tag, observed, expected, cyc);
        end
    endtask

    // Line buffers seen as history: newest and second-newest pixel ever written at column c.
    task automatic lookupColumn(input int c, output logic [7:0] mid, output logic [7:0] top);
        int hits;
        hits = 0;
        mid  = 8'd0;
        top  = 8'd0;
        for (int i = strobes.size() - 1; i >= 0 && hits < 2; i--) begin
            if (strobes[i].wrote && strobes[i].col == c) begin
                if (hits == 0) mid = strobes[i].pix;
                else           top = strobes[i].pix;
                hits++;
            end
        end
    endtask

    // Visible window at cycle v: last three strobes of the line current in v-1, taken by v-2.
    function automatic logic [71:0] modelWindow(input int v);
        logic [7:0] w [3][3];
        int         found;
        int         cur;
        found = 0;
        cur   = lineHist[v-1];
        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 3; c++) w[r][c] = 8'd0;
        end
        for (int i = strobes.size() - 1; i >= 0 && found < 3; i--) begin
            if (strobes[i].line < cur) break;
            if (strobes[i].line == cur && strobes[i].cyc <= v - 2) begin
                w[0][2-found] = strobes[i].top;
                w[1][2-found] = strobes[i].mid;
                w[2][2-found] = strobes[i].pix;
                found++;
            end
        end
        return {w[0][0], w[0][1], w[0][2], w[1][0], w[1][1], w[1][2], w[2][0], w[2][1], w[2][2]};
    endfunction

    task automatic applyStimulus(input logic r, input logic vs, input logic hr, input logic ce,
                                 input logic [7:0] y);
        logic [7:0] mid;
        logic [7:0] top;
        logic [2:0] expFrame;
        strobe_t    s;
        if (cyc >= MAX_CYC - 2) begin
            $display("[TB] FAIL cycleBudget observed=%0d required<%0d", cyc, MAX_CYC - 2);
            $fatal(1, "[TB] cycle budget exhausted");
        end
        if (r) begin
            lineId++;
            linesDone = 0;
            prevHref  = 1'b0;
            prevVs    = 1'b0;
        end else begin
            if (hr && !prevHref) begin
                lineId++;
                colCnt = 0;
            end
            if (ce && hr) begin
                lookupColumn(colCnt, mid, top);
                s.cyc   = cyc;
                s.line  = lineId;
                s.col   = colCnt;
                s.wrote = (colCnt < int'(HDISP));
                s.pix   = y;
                s.mid   = (s.wrote && linesDone >= 1) ? mid : 8'd0;
                s.top   = (s.wrote && linesDone == 2) ? top : 8'd0;
                strobes.push_back(s);
                colCnt++;
            end
            if (vs && !prevVs)                         linesDone = 0;
            else if (!hr && prevHref && linesDone < 2) linesDone++;
            prevHref = hr;
            prevVs   = vs;
        end
        rstHist[cyc]  = r;
        inHist[cyc]   = {vs, hr, ce};
        lineHist[cyc] = lineId;

        rst             = r;
        per_frame_vsync = vs;
        per_frame_href  = hr;
        per_frame_clken = ce;
        per_img_Y       = y;
        @(posedge clk);
        #1;
        cyc++;

        if (cyc < 2 || rstHist[cyc-1] || rstHist[cyc-2]) expFrame = 3'b000;
        else                                             expFrame = inHist[cyc-2];
        checkOutput("window", dutWindow(), modelWindow(cyc));
        checkOutput("frameTiming", {69'd0, matrix_frame_vsync, matrix_frame_href, matrix_frame_clken},
                    {69'd0, expFrame});
    endtask

    task automatic newFrame();
        vsLvl = 1'b0;
        repeat (2) applyStimulus(1'b0, vsLvl, 1'b0, 1'b0, 8'd0);
        vsLvl = 1'b1;
        repeat (2) applyStimulus(1'b0, vsLvl, 1'b0, 1'b0, 8'd0);
    endtask

    // Pixels base+1..base+n; gapped lines idle one cycle (with junk Y) before every strobe.
    task automatic sendLine(input int n, input int base, input bit gapped);
        for (int k = 0; k < n; k++) begin
            if (gapped) applyStimulus(1'b0, vsLvl, 1'b1, 1'b0, 8'($urandom));
            applyStimulus(1'b0, vsLvl, 1'b1, 1'b1, 8'(base + k + 1));
        end
        repeat (2) applyStimulus(1'b0, vsLvl, 1'b0, 1'b0, 8'd0);
    endtask

    initial begin
        int   got;
        int   len;
        logic ce;

        repeat (3) applyStimulus(1'b1, 1'($urandom), 1'($urandom), 1'($urandom), 8'($urandom));
        repeat (2) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
        checkOutput("resetWindow", dutWindow(), 72'd0);
        checkOutput("resetFrame", {69'd0, matrix_frame_vsync, matrix_frame_href, matrix_frame_clken}, 72'd0);

        newFrame();
        sendLine(4, 0, 1'b0);
        checkOutput("line0", dutWindow(), {48'd0, 8'd2, 8'd3, 8'd4});
        sendLine(4, 10, 1'b0);
        checkOutput("line1", dutWindow(), {24'd0, 8'd2, 8'd3, 8'd4, 8'd12, 8'd13, 8'd14});
        sendLine(4, 20, 1'b0);
        checkOutput("line2", dutWindow(), {8'd2, 8'd3, 8'd4, 8'd12, 8'd13, 8'd14, 8'd22, 8'd23, 8'd24});

        newFrame();
        sendLine(4, 0, 1'b1);
        checkOutput("gapLine0", dutWindow(), {48'd0, 8'd2, 8'd3, 8'd4});
        sendLine(4, 10, 1'b1);
        checkOutput("gapLine1", dutWindow(), {24'd0, 8'd2, 8'd3, 8'd4, 8'd12, 8'd13, 8'd14});
        sendLine(4, 20, 1'b1);
        checkOutput("gapLine2", dutWindow(), {8'd2, 8'd3, 8'd4, 8'd12, 8'd13, 8'd14, 8'd22, 8'd23, 8'd24});

        newFrame();
        sendLine(4, 4, 1'b0);
        checkOutput("newFrameLine0", dutWindow(), {48'd0, 8'd6, 8'd7, 8'd8});
        sendLine(4, 40, 1'b0);
        checkOutput("newFrameLine1", dutWindow(), {24'd0, 8'd6, 8'd7, 8'd8, 8'd42, 8'd43, 8'd44});

        applyStimulus(1'b0, vsLvl, 1'b1, 1'b1, 8'd51);
        applyStimulus(1'b0, vsLvl, 1'b1, 1'b1, 8'd52);
        applyStimulus(1'b1, vsLvl, 1'b1, 1'b1, 8'd53);
        repeat (2) applyStimulus(1'b1, vsLvl, 1'b0, 1'b0, 8'd0);
        checkOutput("midResetWindow", dutWindow(), 72'd0);
        repeat (2) applyStimulus(1'b0, vsLvl, 1'b0, 1'b0, 8'd0);
        sendLine(4, 60, 1'b0);
        checkOutput("afterReset", dutWindow(), {48'd0, 8'd62, 8'd63, 8'd64});

        sendLine(6, 30, 1'b0);
        checkOutput("overlong", dutWindow(), {24'd0, 8'd64, 8'd0, 8'd0, 8'd34, 8'd35, 8'd36});
        sendLine(4, 70, 1'b0);
        checkOutput("afterOverlong", dutWindow(),
                    {8'd62, 8'd63, 8'd64, 8'd32, 8'd33, 8'd34, 8'd72, 8'd73, 8'd74});

        for (int k = 0; k < 4; k++) applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 8'(91 + k));
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 8'd0);
        vsLvl = 1'b1;
        repeat (2) applyStimulus(1'b0, vsLvl, 1'b0, 1'b0, 8'd0);
        sendLine(4, 80, 1'b0);
        checkOutput("vsyncRiseHrefFall", dutWindow(), {48'd0, 8'd82, 8'd83, 8'd84});

        for (int f = 0; f < 20; f++) begin
            newFrame();
            for (int l = 0; l < 2 + int'($urandom % 4); l++) begin
                len = 1 + int'($urandom % 6);
                got = 0;
                while (got < len) begin
                    ce = ($urandom % 3) != 0;
                    applyStimulus(1'b0, vsLvl, 1'b1, ce, 8'($urandom));
                    if (ce) got++;
                    if ($urandom % 50 == 0) applyStimulus(1'b1, vsLvl, 1'b1, 1'($urandom), 8'($urandom));
                end
                repeat (1 + $urandom % 3) applyStimulus(1'b0, vsLvl, 1'b0, 1'b0, 8'($urandom));
            end
        end

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
